// File: rtl/sram_axi_bridge_if.sv
// Signal bundle between the CPU-side SRAM strobe interface, the bridge and a
// single-beat AXI3 slave.
//
// Modports:
//   master - the bridge: consumes CPU strobes and AXI responses, drives the
//            completion pulses, read data and all AXI request channels.
//   slave  - the environment: drives CPU strobes and AXI responses, observes
//            the rest.
interface sram_axi_bridge_if;
    // CPU-side SRAM strobes and completions
    logic [31:0] inst_addr;
    logic        inst_ren;
    logic        inst_valid;
    logic [31:0] inst_rd;
    logic [31:0] data_addr;
    logic        data_ren;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rd;

    // AXI read address / read data
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // AXI write address / write data / write response
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  inst_addr, inst_ren, data_addr, data_ren, data_wen, data_wdata,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid,
        output inst_valid, inst_rd, data_valid, data_rd,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready
    );

    modport slave (
        output inst_addr, inst_ren, data_addr, data_ren, data_wen, data_wdata,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid,
        input  inst_valid, inst_rd, data_valid, data_rd,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridge from single-cycle CPU SRAM strobes (inst read, data read, data write)
// to single-beat AXI3 master transactions, one outstanding at a time.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active low
//   bus  - sram_axi_bridge_if.master: CPU strobes/completions and the AXI port
//
// Strobes are parked in one-deep pending slots; from IDLE the highest-priority
// slot (data write > data read > inst read) is launched. kseg0/kseg1 virtual
// addresses are folded onto physical space at launch.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input logic               clk,
    input logic               rst,
    sram_axi_bridge_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp
    } state_e;

    state_e      r_state, w_state_nxt;

    // Pending slots
    logic        r_inst_pend, w_inst_pend_nxt;
    logic [31:0] r_inst_addr, w_inst_addr_nxt;
    logic        r_dr_pend, w_dr_pend_nxt;
    logic [31:0] r_dr_addr, w_dr_addr_nxt;
    logic        r_dw_pend, w_dw_pend_nxt;
    logic [31:0] r_dw_addr, w_dw_addr_nxt;
    logic [3:0]  r_dw_wen, w_dw_wen_nxt;
    logic [31:0] r_dw_wdata, w_dw_wdata_nxt;

    // Source of the read in flight; steers rdata, independent of rid
    logic        r_src_inst, w_src_inst_nxt;

    logic        r_arvalid, w_arvalid_nxt;
    logic [3:0]  r_arid, w_arid_nxt;
    logic [31:0] r_araddr, w_araddr_nxt;
    logic        r_awvalid, w_awvalid_nxt;
    logic [31:0] r_awaddr, w_awaddr_nxt;
    logic        r_wvalid, w_wvalid_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        r_aw_done, w_aw_done_nxt;
    logic        r_w_done, w_w_done_nxt;

    logic        r_inst_valid, w_inst_valid_nxt;
    logic        r_data_valid, w_data_valid_nxt;
    logic [31:0] r_inst_rd, w_inst_rd_nxt;
    logic [31:0] r_data_rd, w_data_rd_nxt;

    logic        w_take_inst, w_take_dr, w_take_dw;
    logic        w_aw_hs, w_w_hs;

    // Response IDs, response codes and rlast carry no information here
    logic        w_unused;
    assign w_unused = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

    // kseg0 (100) and kseg1 (101) both fold onto the low 512 MB
    function automatic logic [31:0] map_addr(input logic [31:0] addr);
        map_addr = (addr[31:30] == 2'b10) ? {3'b000, addr[28:0]} : addr;
    endfunction

    assign w_aw_hs = r_awvalid & bus.awready;
    assign w_w_hs  = r_wvalid & bus.wready;

    always_comb begin
        w_state_nxt      = r_state;
        w_src_inst_nxt   = r_src_inst;
        w_arvalid_nxt    = r_arvalid;
        w_arid_nxt       = r_arid;
        w_araddr_nxt     = r_araddr;
        w_awvalid_nxt    = r_awvalid;
        w_awaddr_nxt     = r_awaddr;
        w_wvalid_nxt     = r_wvalid;
        w_wdata_nxt      = r_wdata;
        w_wstrb_nxt      = r_wstrb;
        w_aw_done_nxt    = r_aw_done;
        w_w_done_nxt     = r_w_done;
        w_inst_valid_nxt = 1'b0;
        w_data_valid_nxt = 1'b0;
        w_inst_rd_nxt    = r_inst_rd;
        w_data_rd_nxt    = r_data_rd;
        w_take_inst      = 1'b0;
        w_take_dr        = 1'b0;
        w_take_dw        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (r_dw_pend) begin
                    w_take_dw     = 1'b1;
                    w_state_nxt   = StWrReq;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_awaddr_nxt  = map_addr(r_dw_addr);
                    w_wdata_nxt   = r_dw_wdata;
                    w_wstrb_nxt   = r_dw_wen;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else if (r_dr_pend) begin
                    w_take_dr      = 1'b1;
                    w_state_nxt    = StRdAddr;
                    w_arvalid_nxt  = 1'b1;
                    w_arid_nxt     = DATA_ID;
                    w_araddr_nxt   = map_addr(r_dr_addr);
                    w_src_inst_nxt = 1'b0;
                end else if (r_inst_pend) begin
                    w_take_inst    = 1'b1;
                    w_state_nxt    = StRdAddr;
                    w_arvalid_nxt  = 1'b1;
                    w_arid_nxt     = INST_ID;
                    w_araddr_nxt   = map_addr(r_inst_addr);
                    w_src_inst_nxt = 1'b1;
                end
            end
            StRdAddr: begin
                if (bus.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_state_nxt   = StRdData;
                end
            end
            StRdData: begin
                if (bus.rvalid) begin
                    w_state_nxt = StIdle;
                    if (r_src_inst) begin
                        w_inst_rd_nxt    = bus.rdata;
                        w_inst_valid_nxt = 1'b1;
                    end else begin
                        w_data_rd_nxt    = bus.rdata;
                        w_data_valid_nxt = 1'b1;
                    end
                end
            end
            StWrReq: begin
                // AW and W retire independently, in any order
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_hs) w_awvalid_nxt = 1'b0;
                if (w_w_hs) w_wvalid_nxt = 1'b0;
                if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = StWrResp;
            end
            StWrResp: begin
                if (bus.bvalid) begin
                    w_state_nxt      = StIdle;
                    w_data_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Slot update: a launch frees the slot, a fresh strobe (re)fills it
        w_inst_pend_nxt = r_inst_pend & ~w_take_inst;
        w_inst_addr_nxt = r_inst_addr;
        if (bus.inst_ren) begin
            w_inst_pend_nxt = 1'b1;
            w_inst_addr_nxt = bus.inst_addr;
        end

        w_dr_pend_nxt  = r_dr_pend & ~w_take_dr;
        w_dr_addr_nxt  = r_dr_addr;
        w_dw_pend_nxt  = r_dw_pend & ~w_take_dw;
        w_dw_addr_nxt  = r_dw_addr;
        w_dw_wen_nxt   = r_dw_wen;
        w_dw_wdata_nxt = r_dw_wdata;
        // A write strobe wins over a simultaneous read strobe
        if (|bus.data_wen) begin
            w_dw_pend_nxt  = 1'b1;
            w_dw_addr_nxt  = bus.data_addr;
            w_dw_wen_nxt   = bus.data_wen;
            w_dw_wdata_nxt = bus.data_wdata;
        end else if (bus.data_ren) begin
            w_dr_pend_nxt = 1'b1;
            w_dr_addr_nxt = bus.data_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_inst_pend  <= 1'b0;
            r_inst_addr  <= '0;
            r_dr_pend    <= 1'b0;
            r_dr_addr    <= '0;
            r_dw_pend    <= 1'b0;
            r_dw_addr    <= '0;
            r_dw_wen     <= '0;
            r_dw_wdata   <= '0;
            r_src_inst   <= 1'b0;
            r_arvalid    <= 1'b0;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_awvalid    <= 1'b0;
            r_awaddr     <= '0;
            r_wvalid     <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_inst_rd    <= '0;
            r_data_rd    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_inst_pend  <= w_inst_pend_nxt;
            r_inst_addr  <= w_inst_addr_nxt;
            r_dr_pend    <= w_dr_pend_nxt;
            r_dr_addr    <= w_dr_addr_nxt;
            r_dw_pend    <= w_dw_pend_nxt;
            r_dw_addr    <= w_dw_addr_nxt;
            r_dw_wen     <= w_dw_wen_nxt;
            r_dw_wdata   <= w_dw_wdata_nxt;
            r_src_inst   <= w_src_inst_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_arid       <= w_arid_nxt;
            r_araddr     <= w_araddr_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_awaddr     <= w_awaddr_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_aw_done    <= w_aw_done_nxt;
            r_w_done     <= w_w_done_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_inst_rd    <= w_inst_rd_nxt;
            r_data_rd    <= w_data_rd_nxt;
        end
    end

    assign bus.inst_valid = r_inst_valid;
    assign bus.inst_rd    = r_inst_rd;
    assign bus.data_valid = r_data_valid;
    assign bus.data_rd    = r_data_rd;

    assign bus.arid    = r_arid;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = 4'd0;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = (r_state == StRdData);

    assign bus.awid    = DATA_ID;
    assign bus.awaddr  = r_awaddr;
    assign bus.awlen   = 4'd0;
    assign bus.awsize  = 3'b010;
    assign bus.awburst = 2'b01;
    assign bus.awvalid = r_awvalid;
    assign bus.wid     = DATA_ID;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wstrb;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = r_wvalid;
    assign bus.bready  = (r_state == StWrResp);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a configurable-latency AXI slave.
module tb_sram_axi_bridge;

    logic clk = 1'b1;
    logic rst;
    always #5 clk = ~clk;

    sram_axi_bridge_if bus ();

    sram_axi_bridge #(
        .INST_ID(4'd0),
        .DATA_ID(4'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Slave knobs
    int          ar_delay = 0;
    int          r_delay  = 0;
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic        echo     = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0;

    // Slave state
    int          ar_cnt, r_cnt, aw_cnt_s, w_cnt_s;
    logic [31:0] lat_araddr;

    // Monitor
    logic [3:0]  ar_ids[$];
    logic [31:0] ar_addrs[$];
    int          aw_hs_cnt = 0;
    int          inst_v_cnt = 0;
    int          data_v_cnt = 0;

    // Slave decides its ready/valid at negedge for the following posedge
    always @(negedge clk) begin
        if (!rst) begin
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
            bus.rid = '0; bus.rlast = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
            bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = '0;
            ar_cnt = 0; r_cnt = 0; aw_cnt_s = 0; w_cnt_s = 0; lat_araddr = '0;
        end else begin
            if (bus.arvalid) begin
                lat_araddr  = bus.araddr;
                bus.arready = (ar_cnt == ar_delay);
                ar_cnt++;
            end else begin
                bus.arready = 1'b0;
                ar_cnt = 0;
            end
            if (bus.rready) begin
                bus.rvalid = (r_cnt == r_delay);
                bus.rdata  = echo ? ~lat_araddr : cfg_rdata;
                bus.rresp  = cfg_rresp;
                bus.rid    = bus.arid;
                bus.rlast  = 1'b1;
                r_cnt++;
            end else begin
                bus.rvalid = 1'b0;
                r_cnt = 0;
            end
            if (bus.awvalid) begin
                bus.awready = (aw_cnt_s == aw_delay);
                aw_cnt_s++;
            end else begin
                bus.awready = 1'b0;
                aw_cnt_s = 0;
            end
            if (bus.wvalid) begin
                bus.wready = (w_cnt_s == w_delay);
                w_cnt_s++;
            end else begin
                bus.wready = 1'b0;
                w_cnt_s = 0;
            end
            bus.bvalid = bus.bready;
            bus.bid    = bus.awid;
            bus.bresp  = 2'b00;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            if (bus.arvalid && bus.arready) begin
                ar_ids.push_back(bus.arid);
                ar_addrs.push_back(bus.araddr);
            end
            if (bus.awvalid && bus.awready) aw_hs_cnt <= aw_hs_cnt + 1;
            if (bus.inst_valid) inst_v_cnt <= inst_v_cnt + 1;
            if (bus.data_valid) data_v_cnt <= data_v_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cpu;
        bus.inst_addr  = '0;
        bus.inst_ren   = 1'b0;
        bus.data_addr  = '0;
        bus.data_ren   = 1'b0;
        bus.data_wen   = '0;
        bus.data_wdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_cpu();
        repeat (3) tick();
        checks++;
        if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
             bus.inst_valid, bus.data_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b required 0000000",
                     {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                      bus.inst_valid, bus.data_valid});
        end
        checks++;
        if ({bus.inst_rd, bus.data_rd, bus.araddr, bus.awaddr, bus.wdata, bus.wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_data: got inst_rd=%h data_rd=%h araddr=%h awaddr=%h wdata=%h wstrb=%b required all 0",
                     bus.inst_rd, bus.data_rd, bus.araddr, bus.awaddr, bus.wdata, bus.wstrb);
        end
        checks++;
        if ({bus.arlen, bus.arsize, bus.arburst, bus.awlen, bus.awsize, bus.awburst, bus.wlast,
             bus.awid, bus.wid} !== {4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 1'b1, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL reset_constants: got arlen=%h arsize=%b arburst=%b awlen=%h awsize=%b awburst=%b wlast=%b awid=%h wid=%h required 0/010/01/0/010/01/1/1/1",
                     bus.arlen, bus.arsize, bus.arburst, bus.awlen, bus.awsize, bus.awburst,
                     bus.wlast, bus.awid, bus.wid);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_inst_fetch;
        cfg_rdata = 32'h3C1D8000;
        bus.inst_addr = 32'hBFC00000;
        bus.inst_ren  = 1'b1;
        tick();
        clear_cpu();
        checks++;
        if (bus.arvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_no_early_ar: got arvalid=%b required 0", bus.arvalid);
        end
        tick();
        checks++;
        if ({bus.arvalid, bus.araddr, bus.arid} !== {1'b1, 32'h1FC00000, 4'd0}) begin
            errors++;
            $display("FAIL fetch_ar: got arvalid=%b araddr=%h arid=%h required 1 1fc00000 0",
                     bus.arvalid, bus.araddr, bus.arid);
        end
        tick();
        checks++;
        if ({bus.rready, bus.inst_valid} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_rdata_phase: got rready=%b inst_valid=%b required 1 0",
                     bus.rready, bus.inst_valid);
        end
        tick();
        checks++;
        if ({bus.inst_valid, bus.inst_rd} !== {1'b1, 32'h3C1D8000}) begin
            errors++;
            $display("FAIL fetch_valid_at_4: got inst_valid=%b inst_rd=%h required 1 3c1d8000",
                     bus.inst_valid, bus.inst_rd);
        end
        cfg_rdata = 32'hDEADDEAD;
        tick();
        checks++;
        if ({bus.inst_valid, bus.inst_rd} !== {1'b0, 32'h3C1D8000}) begin
            errors++;
            $display("FAIL fetch_pulse_hold: got inst_valid=%b inst_rd=%h required 0 3c1d8000",
                     bus.inst_valid, bus.inst_rd);
        end
    endtask

    task automatic test_data_write;
        logic [31:0] prev_rd;
        prev_rd  = bus.data_rd;
        aw_delay = 3;
        w_delay  = 0;
        bus.data_addr  = 32'h80001004;
        bus.data_wen   = 4'b0011;
        bus.data_wdata = 32'h0000BEEF;
        tick();
        clear_cpu();
        tick();
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.awaddr, bus.wstrb, bus.wdata} !==
            {1'b1, 1'b1, 32'h00001004, 4'b0011, 32'h0000BEEF}) begin
            errors++;
            $display("FAIL wr_launch: got awvalid=%b wvalid=%b awaddr=%h wstrb=%b wdata=%h required 1 1 00001004 0011 0000beef",
                     bus.awvalid, bus.wvalid, bus.awaddr, bus.wstrb, bus.wdata);
        end
        tick();
        checks++;
        if ({bus.awvalid, bus.wvalid} !== 2'b10) begin
            errors++;
            $display("FAIL wr_w_first: got awvalid=%b wvalid=%b required 1 0", bus.awvalid, bus.wvalid);
        end
        tick();
        tick();
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.data_valid} !== 3'b100) begin
            errors++;
            $display("FAIL wr_aw_wait: got awvalid=%b wvalid=%b data_valid=%b required 1 0 0",
                     bus.awvalid, bus.wvalid, bus.data_valid);
        end
        tick();
        checks++;
        if ({bus.awvalid, bus.bready, bus.data_valid} !== 3'b010) begin
            errors++;
            $display("FAIL wr_resp_phase: got awvalid=%b bready=%b data_valid=%b required 0 1 0",
                     bus.awvalid, bus.bready, bus.data_valid);
        end
        tick();
        checks++;
        if ({bus.data_valid, bus.data_rd} !== {1'b1, prev_rd}) begin
            errors++;
            $display("FAIL wr_done: got data_valid=%b data_rd=%h required 1 %h",
                     bus.data_valid, bus.data_rd, prev_rd);
        end
        tick();
        checks++;
        if ({bus.data_valid, bus.bready} !== 2'b00) begin
            errors++;
            $display("FAIL wr_pulse: got data_valid=%b bready=%b required 0 0", bus.data_valid, bus.bready);
        end
        aw_delay = 0;
    endtask

    task automatic test_contention;
        int i0, d0;
        logic [3:0]  ids[3];
        logic [31:0] adr[3];
        ar_ids.delete();
        ar_addrs.delete();
        i0 = inst_v_cnt;
        d0 = data_v_cnt;
        echo    = 1'b1;
        r_delay = 3;
        bus.inst_addr = 32'hBFC00100;
        bus.inst_ren  = 1'b1;
        tick();
        clear_cpu();
        tick();
        tick();
        tick();
        checks++;
        if (bus.rready !== 1'b1) begin
            errors++; $display("FAIL cont_in_rdata: got rready=%b required 1", bus.rready);
        end
        bus.data_addr = 32'h80002000;
        bus.data_ren  = 1'b1;
        tick();
        clear_cpu();
        bus.inst_addr = 32'h9FC00010;
        bus.inst_ren  = 1'b1;
        tick();
        clear_cpu();
        for (int k = 0; k < 60 && !(inst_v_cnt == i0 + 2 && data_v_cnt == d0 + 1); k++) tick();
        checks++;
        if ({inst_v_cnt - i0, data_v_cnt - d0} !== {32'd2, 32'd1}) begin
            errors++;
            $display("FAIL cont_completions: got inst=%0d data=%0d required 2 1",
                     inst_v_cnt - i0, data_v_cnt - d0);
        end
        for (int k = 0; k < 3; k++) begin
            ids[k] = (ar_ids.size() > k) ? ar_ids[k] : 4'hx;
            adr[k] = (ar_addrs.size() > k) ? ar_addrs[k] : 32'hx;
        end
        checks++;
        if ({ids[0], ids[1], ids[2]} !== {4'd0, 4'd1, 4'd0} || ar_ids.size() != 3) begin
            errors++;
            $display("FAIL cont_order_ids: got %0d launches ids %h %h %h required 3 launches 0 1 0",
                     ar_ids.size(), ids[0], ids[1], ids[2]);
        end
        checks++;
        if ({adr[0], adr[1], adr[2]} !== {32'h1FC00100, 32'h00002000, 32'h1FC00010}) begin
            errors++;
            $display("FAIL cont_order_addr: got %h %h %h required 1fc00100 00002000 1fc00010",
                     adr[0], adr[1], adr[2]);
        end
        checks++;
        if ({bus.data_rd, bus.inst_rd} !== {32'hFFFFDFFF, 32'hE03FFFEF}) begin
            errors++;
            $display("FAIL cont_data: got data_rd=%h inst_rd=%h required ffffdfff e03fffef",
                     bus.data_rd, bus.inst_rd);
        end
        echo    = 1'b0;
        r_delay = 0;
        tick();
    endtask

    task automatic test_unmapped_error;
        int d0;
        logic [31:0] a;
        logic [3:0]  id;
        ar_ids.delete();
        ar_addrs.delete();
        d0 = data_v_cnt;
        cfg_rdata = 32'h12345678;
        cfg_rresp = 2'b10;
        bus.data_addr = 32'h00400000;
        bus.data_ren  = 1'b1;
        tick();
        clear_cpu();
        for (int k = 0; k < 20 && data_v_cnt == d0; k++) tick();
        a  = (ar_addrs.size() > 0) ? ar_addrs[0] : 32'hx;
        id = (ar_ids.size() > 0) ? ar_ids[0] : 4'hx;
        checks++;
        if ({a, id} !== {32'h00400000, 4'd1}) begin
            errors++;
            $display("FAIL unmapped_ar: got araddr=%h arid=%h required 00400000 1", a, id);
        end
        checks++;
        if (data_v_cnt - d0 != 1 || bus.data_rd !== 32'h12345678) begin
            errors++;
            $display("FAIL slverr_complete: got pulses=%0d data_rd=%h required 1 12345678",
                     data_v_cnt - d0, bus.data_rd);
        end
        cfg_rresp = 2'b00;
        tick();
    endtask

    task automatic test_backpressure;
        cfg_rdata = 32'hCAFEF00D;
        ar_delay  = 5;
        bus.inst_addr = 32'h80000040;
        bus.inst_ren  = 1'b1;
        tick();
        clear_cpu();
        tick();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({bus.arvalid, bus.araddr, bus.inst_valid} !== {1'b1, 32'h00000040, 1'b0}) begin
                errors++;
                $display("FAIL bp_stable_%0d: got arvalid=%b araddr=%h inst_valid=%b required 1 00000040 0",
                         k, bus.arvalid, bus.araddr, bus.inst_valid);
            end
            tick();
        end
        checks++;
        if ({bus.arvalid, bus.inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL bp_after_hs: got arvalid=%b inst_valid=%b required 0 0",
                     bus.arvalid, bus.inst_valid);
        end
        tick();
        checks++;
        if ({bus.inst_valid, bus.inst_rd} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL bp_done: got inst_valid=%b inst_rd=%h required 1 cafef00d",
                     bus.inst_valid, bus.inst_rd);
        end
        ar_delay = 0;
        tick();
    endtask

    task automatic test_rw_same_cycle;
        int d0, aw0, ar0;
        d0  = data_v_cnt;
        aw0 = aw_hs_cnt;
        ar0 = ar_ids.size();
        bus.data_addr  = 32'hA0000010;
        bus.data_ren   = 1'b1;
        bus.data_wen   = 4'b1111;
        bus.data_wdata = 32'h11223344;
        tick();
        clear_cpu();
        tick();
        checks++;
        if ({bus.awvalid, bus.arvalid, bus.awaddr, bus.wdata} !==
            {1'b1, 1'b0, 32'h00000010, 32'h11223344}) begin
            errors++;
            $display("FAIL rw_write_wins: got awvalid=%b arvalid=%b awaddr=%h wdata=%h required 1 0 00000010 11223344",
                     bus.awvalid, bus.arvalid, bus.awaddr, bus.wdata);
        end
        repeat (10) tick();
        checks++;
        if (aw_hs_cnt - aw0 != 1 || ar_ids.size() - ar0 != 0 || data_v_cnt - d0 != 1) begin
            errors++;
            $display("FAIL rw_read_dropped: got aw=%0d ar=%0d pulses=%0d required 1 0 1",
                     aw_hs_cnt - aw0, ar_ids.size() - ar0, data_v_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_read;
        r_delay = 10;
        bus.inst_addr = 32'hBFC00200;
        bus.inst_ren  = 1'b1;
        tick();
        clear_cpu();
        tick();
        tick();
        checks++;
        if (bus.rready !== 1'b1) begin
            errors++; $display("FAIL rst_pre_rdata: got rready=%b required 1", bus.rready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.inst_valid,
             bus.data_valid, bus.inst_rd, bus.data_rd, bus.araddr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_read: got ar=%b aw=%b w=%b r=%b b=%b iv=%b dv=%b inst_rd=%h data_rd=%h araddr=%h required all 0",
                     bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.inst_valid,
                     bus.data_valid, bus.inst_rd, bus.data_rd, bus.araddr);
        end
        rst       = 1'b1;
        r_delay   = 0;
        cfg_rdata = 32'h0BADF00D;
        tick();
        bus.data_addr = 32'h80003000;
        bus.data_ren  = 1'b1;
        tick();
        clear_cpu();
        tick();
        checks++;
        if ({bus.arvalid, bus.araddr, bus.arid} !== {1'b1, 32'h00003000, 4'd1}) begin
            errors++;
            $display("FAIL rst_after_ar: got arvalid=%b araddr=%h arid=%h required 1 00003000 1",
                     bus.arvalid, bus.araddr, bus.arid);
        end
        tick();
        tick();
        checks++;
        if ({bus.data_valid, bus.data_rd} !== {1'b1, 32'h0BADF00D}) begin
            errors++;
            $display("FAIL rst_after_done: got data_valid=%b data_rd=%h required 1 0badf00d",
                     bus.data_valid, bus.data_rd);
        end
    endtask

    initial begin
        clear_cpu();
        test_reset();
        test_inst_fetch();
        test_data_write();
        test_contention();
        test_unmapped_error();
        test_backpressure();
        test_rw_same_cycle();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU-side SRAM interface. Consumes its single-cycle instruction-read, data-read and data-write strobes.
- Converts each strobe into a single-beat AXI3 master transaction and returns a one-cycle valid pulse with read data.
- Serialises inst and data traffic onto one AXI port, one outstanding transaction at a time; data has priority over inst.
- Performs the fixed kseg0/kseg1 virtual-to-physical address mapping.

Parameters:
- INST_ID, 4'd0, AXI ID used for instruction fetches (arid).
- DATA_ID, 4'd1, AXI ID used for data reads and writes (arid/awid).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (rst==0 resets)
- inst_addr  in  32  fetch virtual address
- inst_ren  in  1  fetch request strobe (1 cycle)
- inst_valid  out  1  fetch complete pulse
- inst_rd  out  32  fetch data
- data_addr  in  32  data virtual address
- data_ren  in  1  data read strobe
- data_wen  in  4  byte write enables; nonzero = write strobe
- data_wdata  in  32  store data
- data_valid  out  1  data read/write complete pulse
- data_rd  out  32  load data
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/4/3/2/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1  AXI write address
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1
- wready  in  1
- bid/bresp/bvalid  in  4/2/1
- bready  out  1

Behaviour:
- Reset (rst==0 at posedge): state IDLE; pending slots cleared. All *valid/*ready outputs 0. inst_rd, data_rd, araddr, awaddr, wdata = 0; wstrb = 0.
- Constants: arlen = awlen = 0; arsize = awsize = 3'b010; arburst = awburst = 2'b01; wlast = 1; wid = awid.
- Address map:
  - addr[31:29] = 3'b100 or 3'b101 -> paddr = {3'b000, addr[28:0]}.
  - Otherwise paddr = addr.
- Strobe capture:
  - Strobes are sampled every cycle into one-deep pending slots: inst{addr}, dread{addr}, dwrite{addr, wen, wdata}.
  - data_ren and nonzero data_wen in the same cycle: the write is captured and the read is dropped.
  - A new strobe into an occupied slot overwrites it; upstream guarantees this does not happen.
- Arbitration: in IDLE, priority is dwrite > dread > inst. Launch takes one cycle; the slot is freed at launch.
- A strobe arriving in IDLE is launched on the following cycle (1 cycle from strobe to arvalid/awvalid).
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
  - IDLE -> RD_ADDR: arvalid = 1, arid per source.
  - RD_ADDR -> RD_DATA on arvalid & arready; arvalid drops the same edge. rready = 1 in RD_DATA.
  - RD_DATA -> IDLE on rvalid & rready:
    - Latch rdata into inst_rd or data_rd, selected by the launched source, not by rid.
    - Pulse inst_valid or data_valid for exactly 1 cycle, the cycle after the handshake.
  - IDLE -> WR_REQ: awvalid = wvalid = 1, wstrb = wen.
    - Each drops independently on its own handshake; the aw_done/w_done flags track this.
    - AW and W may complete in either order or in the same cycle.
  - WR_REQ -> WR_RESP when both are done. bready = 1 in WR_RESP.
  - WR_RESP -> IDLE on bvalid: pulse data_valid for 1 cycle; data_rd unchanged.
- Responses:
  - rresp/bresp errors are ignored; the transaction completes normally.
  - inst_rd and data_rd hold their value until the next completion on that channel.
- Minimum latency, zero-wait slave: read strobe -> valid = 4 cycles; write strobe -> valid = 4 cycles.
- A strobe arriving while busy is served immediately after return to IDLE; no idle gap beyond the IDLE cycle.
- Reset mid-transaction: returns to IDLE and drops every outstanding handshake at once. The slave must also be reset.

Test Plan:
- Inst fetch, zero-wait slave:
  - Stimulus: inst_ren = 1 for 1 cycle, inst_addr = 0xBFC00000; slave returns 0x3C1D8000.
  - Required: araddr = 0x1FC00000, arid = 0. inst_valid pulses 1 cycle, 4 cycles after the strobe. inst_rd = 0x3C1D8000, held afterwards.
- Data write, decoupled channels:
  - Stimulus: data_wen = 4'b0011, data_addr = 0x80001004, wdata = 0x0000BEEF. awready delayed 3 cycles, wready immediate.
  - Required: awaddr = 0x00001004, wstrb = 0011, wvalid drops before awvalid. data_valid pulses only after bvalid.
- Contention:
  - Stimulus: data_ren while an inst read is in RD_DATA, then another inst_ren.
  - Required: the pending data read is launched first after IDLE with arid = 1; the inst read follows. No request is lost.
- Unmapped address and error response:
  - Stimulus: data_ren with addr = 0x00400000; slave returns rresp = 2'b10, rdata = 0x12345678.
  - Required: araddr = 0x00400000, data_valid pulses, data_rd = 0x12345678.
- Back-pressure:
  - Stimulus: arready low for 5 cycles.
  - Required: arvalid and araddr are stable throughout; no valid pulse before the handshake.
- Reset mid-read:
  - Stimulus: rst = 0 during RD_DATA.
  - Required: next cycle all valids/readies = 0, inst_rd = data_rd = 0, state IDLE; the next strobe is served normally.
